// File: rtl/inst_prefetch_decoder.sv
// Instruction prefetch queue and 1/2-byte instruction assembler for the 16-bit CPU front end.
// Bytes stream in from a byte-wide memory port; whole instructions leave through a valid/ready register.
module inst_prefetch_decoder #(
  parameter int                QDEPTH   = 4,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic [7:0]        fetch_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        out_bytes,
  output logic [4:0]        out_op,
  output logic [2:0]        out_mode
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  logic              started;
  logic [7:0]        queue_mem [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr_next;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] head_pc;

  logic [7:0]        head_b0;
  logic [7:0]        head_b1;
  logic              head_long;
  logic [CW-1:0]     head_len;
  logic              head_ready;
  logic [15:0]       head_inst;
  logic              slot_free;
  logic              load;
  logic              push;
  logic [CW-1:0]     pop_len;

  // Pointer arithmetic wraps naturally because QDEPTH is a power of two.
  assign rd_ptr_next = rd_ptr + PW'(1);
  assign head_b0     = queue_mem[rd_ptr];
  assign head_b1     = queue_mem[rd_ptr_next];
  assign head_long   = head_b0[7];
  assign head_len    = head_long ? CW'(2) : CW'(1);
  assign head_ready  = (count >= head_len);
  assign head_inst   = head_long ? {head_b0, head_b1} : {head_b0, 8'h00};

  assign slot_free = !out_valid || out_ready;
  assign load      = slot_free && head_ready;
  assign pop_len   = load ? head_len : '0;

  assign fetch_req = started && !flush && (count < DEPTH_C);
  assign push      = fetch_req && fetch_ack;

  assign out_op    = out_inst[15:11];
  assign out_mode  = out_inst[10:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr] <= fetch_data;
    end
  end

  // Flush wins over any push or pop presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= RESET_PC;
      head_pc    <= RESET_PC;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= flush_pc;
      head_pc    <= flush_pc;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        fetch_addr <= fetch_addr + ADDR_W'(1);
      end
      if (load) begin
        rd_ptr  <= rd_ptr + PW'(head_len);
        head_pc <= head_pc + ADDR_W'(head_len);
      end
      count <= count + CW'(push) - pop_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= 16'h0000;
      out_pc    <= RESET_PC;
      out_bytes <= 2'd1;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      out_valid <= head_ready;
      if (head_ready) begin
        out_inst  <= head_inst;
        out_pc    <= head_pc;
        out_bytes <= head_long ? 2'd2 : 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_prefetch_decoder.sv
// Randomized bench for inst_prefetch_decoder: a memory image drives fetches, and a scoreboard
// built by walking the image instruction by instruction checks every accepted output.
module tb_inst_prefetch_decoder;

  localparam int          QDEPTH   = 4;
  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] flush_pc;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic [1:0]  out_bytes;
  logic [4:0]  out_op;
  logic [2:0]  out_mode;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [1:0]  len;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  image [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;
  int          accepted = 0;
  int          ack_count = 0;
  int          ready_pct = 100;
  int          ack_pct = 100;
  bit          rebuild_pending = 0;
  logic [15:0] rebuild_pc;
  int          edges_to_valid;

  inst_prefetch_decoder #(
    .QDEPTH   (QDEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_bytes  (out_bytes),
    .out_op     (out_op),
    .out_mode   (out_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference program: walk the image from start_pc using the length rule.
  function automatic void build_expected(input logic [15:0] start_pc);
    logic [15:0] pc;
    logic [7:0]  b0;
    exp_t        e;
    pc = start_pc;
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      b0   = image[pc];
      e.pc = pc;
      if (b0[7]) begin
        e.inst = {b0, image[pc + 16'd1]};
        e.len  = 2'd2;
      end else begin
        e.inst = {b0, 8'h00};
        e.len  = 2'd1;
      end
      exp_q.push_back(e);
      pc = pc + 16'(e.len);
    end
  endfunction

  task automatic apply_stimulus(input bit do_flush, input logic [15:0] fpc);
    @(negedge clk);
    if (rebuild_pending) begin
      build_expected(rebuild_pc);
      rebuild_pending = 0;
    end
    flush     = do_flush;
    flush_pc  = fpc;
    out_ready = ($urandom_range(99) < ready_pct);
    if (do_flush) begin
      rebuild_pending = 1;
      rebuild_pc      = fpc;
    end
    #1;
    fetch_ack  = fetch_req && ($urandom_range(99) < ack_pct);
    fetch_data = fetch_ack ? image[fetch_addr] : 8'($urandom);
  endtask

  task automatic run_random(input int cycles, input int flush_pct);
    bit          f;
    logic [15:0] p;
    for (int i = 0; i < cycles; i++) begin
      f = ($urandom_range(99) < flush_pct);
      p = ($urandom_range(3) == 0) ? 16'hFFFE + 16'($urandom_range(1)) : 16'($urandom);
      apply_stimulus(f, p);
    end
  endtask

  // Monitor: samples just before each rising edge and scores every accepted instruction.
  initial begin : monitor
    exp_t        e;
    logic [41:0] prev_out;
    bit          hold_prev;
    hold_prev = 0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        hold_prev = 0;
      end else begin
        if (hold_prev) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_hold", {out_inst, out_pc, out_bytes, out_op, out_mode}, prev_out);
        end
        hold_prev = out_valid && !out_ready && !flush;
        prev_out  = {out_inst, out_pc, out_bytes, out_op, out_mode};
        if (flush) check("req_in_flush", fetch_req, 1'b0);
        if (fetch_req && fetch_ack) ack_count++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got pc %0h, expected no instruction", out_pc);
          end else begin
            e = exp_q.pop_front();
            check("out_inst", out_inst, e.inst);
            check("out_pc", out_pc, e.pc);
            check("out_bytes", out_bytes, e.len);
            check("out_op", out_op, e.inst[15:11]);
            check("out_mode", out_mode, e.inst[10:8]);
            accepted++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    rst_n      = 1'b0;
    flush      = 1'b0;
    flush_pc   = 16'h0000;
    out_ready  = 1'b0;
    fetch_ack  = 1'b0;
    fetch_data = 8'h00;
    for (int i = 0; i < 65536; i++) image[i] = 8'($urandom);
    image[0] = 8'h01;
    image[1] = 8'h00;
    for (int i = 2; i < 16; i++) image[i] = 8'(i);
    image[16'h0010] = 8'h88;
    image[16'h0011] = 8'h05;
    build_expected(RESET_PC);

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_fetch_req", fetch_req, 1'b0);
    check("rst_fetch_addr", fetch_addr, RESET_PC);
    check("rst_out_pc", out_pc, RESET_PC);
    check("rst_out_inst", out_inst, 16'h0000);
    check("rst_out_bytes", out_bytes, 2'd1);
    check("rst_out_op_mode", {out_op, out_mode}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_before_start", fetch_req, 1'b0);

    ready_pct = 0;
    ack_pct   = 100;
    apply_stimulus(0, 16'h0000);
    check("req_after_start", fetch_req, 1'b1);

    edges_to_valid = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 16'h0000);
      edges_to_valid++;
      if (out_valid) break;
    end
    check("ack_to_valid_edges", edges_to_valid, 2);

    repeat (20) apply_stimulus(0, 16'h0000);
    check("bp_fetch_req", fetch_req, 1'b0);
    check("bp_ack_count", ack_count, 1 + QDEPTH);
    check("bp_fetch_addr", fetch_addr, RESET_PC + 16'(1 + QDEPTH));

    ready_pct = 100;
    repeat (40) apply_stimulus(0, 16'h0000);
    ready_pct = 0;
    repeat (5) apply_stimulus(0, 16'h0000);
    check("pre_flush_valid", out_valid, 1'b1);
    apply_stimulus(1, 16'h0100);
    apply_stimulus(0, 16'h0000);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_fetch_addr", fetch_addr, 16'h0100);
    check("flush_req_next", fetch_req, 1'b1);

    ready_pct = 70;
    ack_pct   = 70;
    run_random(200, 0);

    image[16'hFFFF] = 8'hC0;
    image[16'h0000] = 8'h07;
    image[16'h0001] = 8'h05;
    apply_stimulus(1, 16'hFFFF);
    run_random(100, 0);
    run_random(2000, 2);

    ready_pct = 0;
    repeat (6) apply_stimulus(0, 16'h0000);
    #1;
    rst_n     = 1'b0;
    fetch_ack = 1'b0;
    flush     = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_fetch_req", fetch_req, 1'b0);
    check("async_fetch_addr", fetch_addr, RESET_PC);
    check("async_out_pc", out_pc, RESET_PC);
    check("async_out_inst", out_inst, 16'h0000);
    check("async_out_bytes", out_bytes, 2'd1);
    repeat (2) @(negedge clk);
    rst_n           = 1'b1;
    rebuild_pending = 0;
    build_expected(RESET_PC);
    ready_pct = 70;
    run_random(300, 0);

    check("liveness", accepted > 300, 1'b1);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
